// File: rtl/ad9648_spi_master.sv
// ad9648_spi_master: 3-wire SPI master for the AD9648 configuration port.
// Sends a TxRegWidth-bit frame MSB first (bit TxRegWidth-1 = R/W, 1 = read).
// In SHIFT, sclk_o spends ClkDiv clk_i cycles low, then ClkDiv high, per bit.
// HOLD keeps csb_o low for ClkDiv cycles after the last bit.
// GAP keeps csb_o high for ClkDiv cycles before the next frame can start.
// Optional feature macro: SPI_READBACK_EN. When it is defined and the frame is
// a read, SDIO is turned around for the last RxRegWidth bits and rx_reg_o is
// loaded from sdio_i.
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   tx_reg_i              frame to send
//   transfer_start_i      one-cycle start pulse, accepted only in IDLE
//   rx_reg_o              last read data
//   transfer_done_o       one-cycle completion pulse
//   busy_o                high from start acceptance until IDLE again
//   sclk_o, csb_o         SPI clock (idle low), chip select (active low)
//   sdio_o, sdio_oe_o     serial data out and its drive enable
//   sdio_i                serial data in
module ad9648_spi_master #(
  parameter int unsigned TxRegWidth = 24,
  parameter int unsigned RxRegWidth = 8,
  parameter int unsigned ClkDiv     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [TxRegWidth-1:0] tx_reg_i,
  input  logic                  transfer_start_i,
  output logic [RxRegWidth-1:0] rx_reg_o,
  output logic                  transfer_done_o,
  output logic                  busy_o,
  output logic                  sclk_o,
  output logic                  csb_o,
  output logic                  sdio_o,
  output logic                  sdio_oe_o,
  input  logic                  sdio_i
);

  localparam int unsigned DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int unsigned BitW = (TxRegWidth > 2) ? $clog2(TxRegWidth) : 1;
  localparam logic [DivW-1:0] DivLast  = DivW'(ClkDiv - 1);
  localparam logic [BitW-1:0] BitFirst = BitW'(TxRegWidth - 1);
  localparam logic [BitW-1:0] RxStart  = BitW'(RxRegWidth);

`ifdef SPI_READBACK_EN
  localparam bit ReadbackEn = 1'b1;
`else
  localparam bit ReadbackEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_e;

  state_e                state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [BitW-1:0]       bit_q, bit_d;
  // Holds the bits still to be sent after the one currently on sdio_o.
  logic [TxRegWidth-2:0] tx_shift_q, tx_shift_d;
  logic [RxRegWidth-1:0] rx_shift_q, rx_shift_d;
  logic [RxRegWidth-1:0] rx_reg_q, rx_reg_d;
  logic                  rd_q, rd_d;
  logic                  sclk_q, sclk_d;
  logic                  csb_q, csb_d;
  logic                  sdio_q, sdio_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  div_end;

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_reg_d   = rx_reg_q;
    rd_d       = rd_q;
    sclk_d     = sclk_q;
    csb_d      = csb_q;
    sdio_d     = sdio_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_end    = (div_q == DivLast);

    unique case (state_q)
      IDLE: begin
        if (transfer_start_i) begin
          state_d    = SHIFT;
          tx_shift_d = tx_reg_i[TxRegWidth-2:0];
          sdio_d     = tx_reg_i[TxRegWidth-1];
          rd_d       = ReadbackEn & tx_reg_i[TxRegWidth-1];
          bit_d      = BitFirst;
          div_d      = '0;
          rx_shift_d = '0;
          sclk_d     = 1'b0;
          csb_d      = 1'b0;
          oe_d       = 1'b1;
          busy_d     = 1'b1;
        end
      end

      SHIFT: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising transition: slave data is sampled for the last bits of a read.
            sclk_d = 1'b1;
            if (rd_q && (bit_q < RxStart)) begin
              rx_shift_d = {rx_shift_q[RxRegWidth-2:0], sdio_i};
            end
          end else begin
            // Falling transition: the only point where sdio_o may change.
            sclk_d = 1'b0;
            if (bit_q == '0) begin
              state_d = HOLD;
            end else begin
              bit_d      = bit_q - 1'b1;
              sdio_d     = tx_shift_q[TxRegWidth-2];
              tx_shift_d = {tx_shift_q[TxRegWidth-3:0], 1'b0};
              if (rd_q && (bit_q == RxStart)) begin
                oe_d = 1'b0;
              end
            end
          end
        end
      end

      HOLD: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d   = '0;
          state_d = GAP;
          csb_d   = 1'b1;
          oe_d    = 1'b0;
          sdio_d  = 1'b0;
          done_d  = 1'b1;
          if (rd_q) begin
            rx_reg_d = rx_shift_q;
          end
        end
      end

      GAP: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_reg_q   <= '0;
      rd_q       <= 1'b0;
      sclk_q     <= 1'b0;
      csb_q      <= 1'b1;
      sdio_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_reg_q   <= rx_reg_d;
      rd_q       <= rd_d;
      sclk_q     <= sclk_d;
      csb_q      <= csb_d;
      sdio_q     <= sdio_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rx_reg_o        = rx_reg_q;
  assign transfer_done_o = done_q;
  assign busy_o          = busy_q;
  assign sclk_o          = sclk_q;
  assign csb_o           = csb_q;
  assign sdio_o          = sdio_q;
  assign sdio_oe_o       = oe_q;

endmodule

// File: tb/tb_ad9648_spi_master.sv
// Directed bench for ad9648_spi_master: default instance (ClkDiv=4) and a
// ClkDiv=1 instance. Outputs are sampled 1 ns after the rising clk edge by the
// stimulus and on the falling edge by the frame monitor.
module tb_ad9648_spi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] tx_reg;
  logic        start;
  logic [7:0]  rx;
  logic        done, busy, sclk, csb, sdio, oe, sdio_in;

  logic [23:0] tx_reg1;
  logic        start1;
  logic [7:0]  rx1;
  logic        done1, busy1, sclk1, csb1, sdio1, oe1;
  logic        sdio_in1 = 1'b0;

  always #5 clk = ~clk;

  ad9648_spi_master dut (
    .clk_i(clk), .rst_n_i(rst_n), .tx_reg_i(tx_reg), .transfer_start_i(start),
    .rx_reg_o(rx), .transfer_done_o(done), .busy_o(busy), .sclk_o(sclk),
    .csb_o(csb), .sdio_o(sdio), .sdio_oe_o(oe), .sdio_i(sdio_in)
  );

  ad9648_spi_master #(.ClkDiv(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .tx_reg_i(tx_reg1), .transfer_start_i(start1),
    .rx_reg_o(rx1), .transfer_done_o(done1), .busy_o(busy1), .sclk_o(sclk1),
    .csb_o(csb1), .sdio_o(sdio1), .sdio_oe_o(oe1), .sdio_i(sdio_in1)
  );

`ifdef SPI_READBACK_EN
  localparam logic [7:0] ExpRdRx   = 8'hA5;
  localparam int         ExpOeLow  = 8;
`else
  localparam logic [7:0] ExpRdRx   = 8'h00;
  localparam int         ExpOeLow  = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Frame monitor (dut): counts on the falling clk edge.
  int          csb_low_cnt, rise_cnt, done_cnt, oe_low_rises, sdio_bad;
  int          csb_hi_run = 0;
  int          last_gap = 0;
  logic [23:0] sdio_cap;
  logic [7:0]  rx_at_done;
  logic        csb_at_done, oe_at_done, busy_at_done;
  logic        sclk_p = 1'b0, csb_p = 1'b1, sdio_p = 1'b0;
  logic [7:0]  rd_pat = 8'hA5;

  // Slave model: presents read data bit k of the last 8 before the k-th rising sclk.
  assign sdio_in = (rise_cnt >= 16 && rise_cnt < 24) ? rd_pat[3'(23 - rise_cnt)] : 1'b0;

  always @(negedge clk) begin
    if (!csb) csb_low_cnt++;
    if (done) begin
      done_cnt++;
      rx_at_done   = rx;
      csb_at_done  = csb;
      oe_at_done   = oe;
      busy_at_done = busy;
    end
    if (sclk && !sclk_p) begin
      rise_cnt++;
      sdio_cap = {sdio_cap[22:0], sdio};
      if (!oe) oe_low_rises++;
    end
    if (!csb && !csb_p && (sdio !== sdio_p) && !(sclk_p && !sclk)) sdio_bad++;
    if (csb) csb_hi_run++;
    else begin
      if (csb_hi_run != 0) last_gap = csb_hi_run;
      csb_hi_run = 0;
    end
    sclk_p = sclk;
    csb_p  = csb;
    sdio_p = sdio;
  end

  task automatic clear_mon();
    csb_low_cnt  = 0;
    rise_cnt     = 0;
    done_cnt     = 0;
    oe_low_rises = 0;
    sdio_bad     = 0;
    sdio_cap     = '0;
    rx_at_done   = '0;
    csb_at_done  = 1'b0;
    oe_at_done   = 1'b1;
    busy_at_done = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [23:0] frame);
    tx_reg = frame;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_frame(input string tag, input logic [23:0] frame, input logic [7:0] exp_rx);
    check({tag, "_idle"},    32'(busy), 0);
    check({tag, "_rises"},   rise_cnt, 24);
    check({tag, "_bits"},    32'(sdio_cap), 32'(frame));
    check({tag, "_csb_low"}, csb_low_cnt, 196);
    check({tag, "_done"},    done_cnt, 1);
    check({tag, "_stable"},  sdio_bad, 0);
    check({tag, "_rx"},      32'(rx), 32'(exp_rx));
  endtask

  initial begin
    int          c1_low, tog1, rise1, done1_cnt;
    logic [23:0] cap1;
    logic        prev1;

    rst_n = 1'b0; start = 1'b0; tx_reg = '0; start1 = 1'b0; tx_reg1 = '0;
    clear_mon();
    repeat (3) @(posedge clk); #1;

    // Reset values.
    check("rst_csb",  32'(csb),  1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_sdio", 32'(sdio), 0);
    check("rst_oe",   32'(oe),   0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rx",   32'(rx),   0);

    // Write frame, start presented on the first edge after reset release.
    rst_n = 1'b1;
    pulse_start(24'h000820);
    check("wr_first_csb",  32'(csb),  0);
    check("wr_first_busy", 32'(busy), 1);
    check("wr_first_oe",   32'(oe),   1);
    check("wr_first_sclk", 32'(sclk), 0);
    wait_idle(400);
    check_frame("wr", 24'h000820, 8'h00);
    check("wr_done_csb",  32'(csb_at_done),  1);
    check("wr_done_oe",   32'(oe_at_done),   0);
    check("wr_done_busy", 32'(busy_at_done), 1);
    check("wr_oe_low",    oe_low_rises, 0);

    // Read frame: slave model returns 0xA5 on the last 8 bits.
    clear_mon();
    pulse_start(24'h800100);
    wait_idle(400);
    check_frame("rd", 24'h800100, ExpRdRx);
    check("rd_oe_low",  oe_low_rises, ExpOeLow);
    check("rd_rx_done", 32'(rx_at_done), 32'(ExpRdRx));

    // Second start 50 cycles into a frame is ignored.
    clear_mon();
    pulse_start(24'h123456);
    repeat (49) @(posedge clk);
    #1;
    tx_reg = 24'hFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(400);
    repeat (20) @(posedge clk);
    #1;
    check_frame("busy_ign", 24'h123456, ExpRdRx);
    check("busy_ign_csb", 32'(csb), 1);

    // Reset in the middle of bit 10's high phase.
    clear_mon();
    pulse_start(24'hABCDEF);
    for (int i = 0; i < 400 && rise_cnt < 11; i++) begin
      @(posedge clk); #1;
    end
    check("mid_pre_sclk", 32'(sclk), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_csb",  32'(csb),  1);
    check("mid_rst_sclk", 32'(sclk), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_oe",   32'(oe),   0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_nodone", done_cnt, 0);
    check("mid_rst_rx",     32'(rx),  0);
    rst_n = 1'b1;
    clear_mon();
    pulse_start(24'h5A5A5A);
    wait_idle(400);
    check_frame("post_rst", 24'h5A5A5A, 8'h00);

    // Back-to-back: start issued in the cycle busy falls.
    clear_mon();
    pulse_start(24'h0F0F0F);
    wait_idle(400);
    check("b2b_first_done", done_cnt, 1);
    clear_mon();
    pulse_start(24'hF0F0F0);
    check("b2b_accept_csb",  32'(csb),  0);
    check("b2b_accept_busy", 32'(busy), 1);
    wait_idle(400);
    check_frame("b2b", 24'hF0F0F0, 8'h00);
    check("b2b_gap_ge_div", 32'(last_gap >= 4), 1);

    // ClkDiv=1 instance.
    c1_low = 0; tog1 = 0; rise1 = 0; done1_cnt = 0; cap1 = '0; prev1 = 1'b0;
    tx_reg1 = 24'h000820; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 200 && busy1; i++) begin
      if (!csb1) c1_low++;
      if (sclk1 !== prev1) tog1++;
      if (sclk1 && !prev1) begin
        rise1++;
        cap1 = {cap1[22:0], sdio1};
      end
      if (done1) done1_cnt++;
      prev1 = sclk1;
      @(posedge clk); #1;
    end
    check("div1_idle",    32'(busy1), 0);
    check("div1_csb_low", c1_low, 49);
    check("div1_toggles", tog1, 48);
    check("div1_rises",   rise1, 24);
    check("div1_bits",    32'(cap1), 32'h000820);
    check("div1_done",    done1_cnt, 1);
    check("div1_rx",      32'(rx1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

endmodule
